gray_sum_pipe: RTL and testbench

GRAY_SUM_PIPE -- requirements
Module: gray_sum_pipe

---
 rtl/gray_pkg.sv | 18 +
 rtl/gray_sum_pipe_if.sv | 25 ++
 rtl/gray_pos_counter.sv | 51 +++++
 rtl/gray_sum_pipe.sv | 86 ++++++++
 tb/tb_gray_sum_pipe.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/gray_pkg.sv
// Shared constants, types and the saturation helper for the grayscale summing pipeline.
package gray_pkg;

  localparam int SUM_W     = 12;
  localparam int N_TERMS   = 11;
  localparam int GRAY_MAX  = 255;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;
  localparam int POS_W     = 12;

  typedef logic [SUM_W-1:0] sum_t;
  typedef logic [POS_W-1:0] pos_t;

  function automatic logic [7:0] sat8(input sum_t s);
    return (s > sum_t'(GRAY_MAX)) ? 8'(GRAY_MAX) : s[7:0];
  endfunction

endpackage

// File: rtl/gray_sum_pipe_if.sv
// Pixel stream bundle: shifted-term input side and gray output side with valid/ready.
interface gray_sum_pipe_if;
  import gray_pkg::*;

  logic [N_TERMS-1:0][7:0] in_term;
  logic                    in_valid;
  logic                    in_ready;
  logic [7:0]              out_gray;
  logic                    out_valid;
  logic                    out_ready;
  logic                    out_eol;
  logic                    out_eof;

  // master = pixel source / sink side, slave = the pipeline itself
  modport master (
    output in_term, in_valid, out_ready,
    input  in_ready, out_gray, out_valid, out_eol, out_eof
  );

  modport slave (
    input  in_term, in_valid, out_ready,
    output in_ready, out_gray, out_valid, out_eol, out_eof
  );

endinterface

// File: rtl/gray_pos_counter.sv
// Column/row tracker for the output stream; advances on output handshakes only.
module gray_pos_counter
  import gray_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid,
  input  logic ready,
  output logic eol,
  output logic eof
);

  pos_t col_reg, col_next;
  pos_t row_reg, row_next;
  logic last_col;
  logic last_row;
  logic hs;

  assign hs       = valid & ready;
  assign last_col = (col_reg == pos_t'(IMG_W - 1));
  assign last_row = (row_reg == pos_t'(IMG_H - 1));
  assign eol      = last_col & valid;
  assign eof      = eol & last_row;

  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (hs) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : row_reg + pos_t'(1);
      end else begin
        col_next = col_reg + pos_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

endmodule

// File: rtl/gray_sum_pipe.sv
// Three-stage RGB-to-gray adder tree with saturation, global-enable stall and line/frame flags.
module gray_sum_pipe
  import gray_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  gray_sum_pipe_if.slave  bus,
  output logic            sat_seen
);

  logic en;
  sum_t term_ext [N_TERMS];

  logic v1_reg, v2_reg, v3_reg;
  sum_t sr_reg, sg_reg, sb_reg;
  sum_t srg_reg, sb2_reg;
  logic [7:0] gray_reg;
  logic sat_seen_reg;

  sum_t sr_next, sg_next, sb_next, s_next;
  logic over_next;

  // One enable for every stage: the pipe moves whenever the output slot is free or being taken
  assign en          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = en;

  generate
    for (genvar gi = 0; gi < N_TERMS; gi++) begin : g_ext
      assign term_ext[gi] = sum_t'(bus.in_term[gi]);
    end
  endgenerate

  assign sr_next   = term_ext[0] + term_ext[1] + term_ext[2];
  assign sg_next   = term_ext[3] + term_ext[4] + term_ext[5] + term_ext[6];
  assign sb_next   = term_ext[7] + term_ext[8] + term_ext[9] + term_ext[10];
  assign s_next    = srg_reg + sb2_reg;
  assign over_next = (s_next > sum_t'(GRAY_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_reg       <= 1'b0;
      v2_reg       <= 1'b0;
      v3_reg       <= 1'b0;
      sr_reg       <= '0;
      sg_reg       <= '0;
      sb_reg       <= '0;
      srg_reg      <= '0;
      sb2_reg      <= '0;
      gray_reg     <= '0;
      sat_seen_reg <= 1'b0;
    end else if (en) begin
      v1_reg   <= bus.in_valid;
      sr_reg   <= sr_next;
      sg_reg   <= sg_next;
      sb_reg   <= sb_next;
      v2_reg   <= v1_reg;
      srg_reg  <= sr_reg + sg_reg;
      sb2_reg  <= sb_reg;
      v3_reg   <= v2_reg;
      gray_reg <= sat8(s_next);
      if (v2_reg && over_next) begin
        sat_seen_reg <= 1'b1;
      end
    end
  end

  assign bus.out_valid = v3_reg;
  assign bus.out_gray  = gray_reg;
  assign sat_seen      = sat_seen_reg;

  gray_pos_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .valid (v3_reg),
    .ready (bus.out_ready),
    .eol   (bus.out_eol),
    .eof   (bus.out_eof)
  );

endmodule

// File: tb/tb_gray_sum_pipe.sv
// Scoreboard bench for gray_sum_pipe on a 4x2 frame: sums, saturation, stalls, eol/eof and reset.
module tb_gray_sum_pipe;
  import gray_pkg::*;

  typedef struct {
    logic [7:0] gray;
    logic       eol;
    logic       eof;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sat_seen;

  int   errors = 0;
  int   checks = 0;
  int   idx = 0;
  bit   rand_rdy = 1'b0;
  exp_t sb_q[$];
  exp_t mon_e;
  exp_t push_e;

  gray_sum_pipe_if bus ();

  gray_sum_pipe #(
    .IMG_W (4),
    .IMG_H (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .sat_seen (sat_seen)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Monitor: pop/compare on output handshake, push model result on input handshake
  always @(negedge clk) begin
    if (rst_n) begin
      check_val("in_ready", {31'd0, bus.in_ready}, {31'd0, bus.out_ready | ~bus.out_valid});
      if (bus.out_valid && bus.out_ready) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_out", 32'd1, 32'd0);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("gray", {24'd0, bus.out_gray}, {24'd0, mon_e.gray});
          check_val("eol", {31'd0, bus.out_eol}, {31'd0, mon_e.eol});
          check_val("eof", {31'd0, bus.out_eof}, {31'd0, mon_e.eof});
          $display("out pixel gray=%0d eol=%0d eof=%0d", bus.out_gray, bus.out_eol, bus.out_eof);
        end
      end else if (!bus.out_valid) begin
        check_val("eol_idle", {31'd0, bus.out_eol | bus.out_eof}, 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
        int s;
        s = 0;
        for (int i = 0; i < N_TERMS; i++) s += int'(bus.in_term[i]);
        push_e.gray = (s > 255) ? 8'd255 : 8'(s);
        push_e.eol  = ((idx % 4) == 3);
        push_e.eof  = ((idx % 8) == 7);
        idx++;
        sb_q.push_back(push_e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [N_TERMS-1:0][7:0] tv);
    bit acc;
    bus.in_term  = tv;
    bus.in_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 50 && !acc; c++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
    end
    if (!acc) check_val("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure_latency(input string tag);
    int lat;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check_val(tag, lat, 32'd3);
  endtask

  task automatic drain();
    bus.in_valid  = 1'b0;
    rand_rdy      = 1'b0;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 200 && sb_q.size() != 0; c++) tick();
    tick();
    check_val("drain_left", sb_q.size(), 32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check_val("rst_out_gray", {24'd0, bus.out_gray}, 32'd0);
    check_val("rst_eol_eof", {30'd0, bus.out_eol, bus.out_eof}, 32'd0);
    check_val("rst_sat_seen", {31'd0, sat_seen}, 32'd0);
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    sb_q.delete();
    idx = 0;
    tick();
    rst_n = 1'b1;
    $display("reset released");
  endtask

  logic [N_TERMS-1:0][7:0] t_white;
  logic [N_TERMS-1:0][7:0] t_max;
  logic [N_TERMS-1:0][7:0] t_rand;
  logic [7:0] white_list [N_TERMS] = '{8'd63, 8'd7, 8'd3, 8'd127, 8'd15, 8'd3, 8'd1, 8'd15, 8'd7, 8'd3, 8'd1};

  initial begin
    for (int i = 0; i < N_TERMS; i++) begin
      t_white[i] = white_list[i];
      t_max[i]   = 8'd255;
    end
    bus.in_term   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    #2;
    do_reset();

    // white pixel: 245, exact latency, no saturation
    send(t_white);
    measure_latency("lat_white");
    drain();
    check_val("sat_after_white", {31'd0, sat_seen}, 32'd0);

    // all-255 terms saturate and set the sticky flag
    send(t_max);
    measure_latency("lat_max");
    check_val("sat_set", {31'd0, sat_seen}, 32'd1);
    drain();
    repeat (3) tick();
    check_val("sat_sticky", {31'd0, sat_seen}, 32'd1);

    // idle input: nothing comes out, counters stay put
    do_reset();
    bus.in_term = '0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_val("idle_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    // 9 pixels on a 4x2 frame: eol on 4 and 8, eof on 8, 9th back at col 0
    for (int p = 0; p < 9; p++) begin
      for (int i = 0; i < N_TERMS; i++) t_rand[i] = 8'($urandom_range(0, 30));
      send(t_rand);
    end
    drain();

    // random output backpressure with continuous input
    bus.out_ready = 1'b0;
    rand_rdy = 1'b1;
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < N_TERMS; i++)
        t_rand[i] = (p % 3 == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 25));
      send(t_rand);
    end
    drain();

    // reset with three pixels in flight
    for (int p = 0; p < 3; p++) send(t_white);
    check_val("inflight_valid", {31'd0, bus.out_valid}, 32'd1);
    do_reset();
    send(t_white);
    measure_latency("lat_after_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
